// File: rtl/rectify_fetch_if.sv
// rectify_fetch_if: bundles the coordinate stream, pixel stream and AXI4 read channels.
// modport master = fetch-stage view, modport slave = environment (warper/memory/sink) view.
interface rectify_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  // coordinate stream in
  logic [31:0]           s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  // pixel stream out
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  // AXI read address
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  // AXI read data
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    output m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    input  m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/rectify_fetch.sv
// rectify_fetch: per-coordinate single-beat AXI4 pixel read, emitted in order on AXI-Stream.
// Ports: m_axi_aclk, m_axi_aresetn (sync, active-low), start (accept enable), bus (rectify_fetch_if.master).
module rectify_fetch #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  ID_WIDTH   = 8,
  parameter int                  IMG_W      = 6,
  parameter int                  IMG_H      = 4,
  parameter int unsigned         BASE_ADDR  = 0,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              start,
  rectify_fetch_if.master   bus
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int ARSIZE = $clog2(BPW);

  localparam logic signed [31:0] L_W    = IMG_W;
  localparam logic signed [31:0] L_H    = IMG_H;
  localparam logic        [31:0] L_BASE = BASE_ADDR;
  localparam logic        [31:0] L_BPW  = BPW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT
  } state_t;

  state_t                  r_state;
  logic                    r_s_tready;
  logic                    r_arvalid;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic                    r_rready;
  logic                    r_m_tvalid;
  logic                    r_m_tlast;
  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic                    r_last;

  logic signed [31:0]      w_x;
  logic signed [31:0]      w_y;
  logic                    w_inb;
  logic        [31:0]      w_off;
  logic        [31:0]      w_addr;
  logic                    w_acc;
  logic                    w_unused;

  // coordinates are signed 16-bit, widened so the bounds test sees negatives
  assign w_x   = {{16{bus.s_axis_tdata[15]}}, bus.s_axis_tdata[15:0]};
  assign w_y   = {{16{bus.s_axis_tdata[31]}}, bus.s_axis_tdata[31:16]};
  assign w_inb = (w_x >= 0) && (w_x < L_W) &&
                 (w_y >= 0) && (w_y < L_H);
  assign w_off  = 32'(w_y * L_W + w_x);
  assign w_addr = L_BASE + w_off * L_BPW;
  assign w_acc  = bus.s_axis_tvalid && r_s_tready;

  assign w_unused = &{1'b0, bus.m_axi_rid, bus.m_axi_rlast, w_addr};

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'(ARSIZE);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0011;
  assign bus.m_axi_arprot  = 3'b000;

  assign bus.s_axis_tready = r_s_tready;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_rready  = r_rready;
  assign bus.m_axis_tvalid = r_m_tvalid;
  assign bus.m_axis_tlast  = r_m_tlast;
  assign bus.m_axis_tdata  = r_m_tdata;

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_state    <= S_IDLE;
      r_s_tready <= 1'b0;
      r_arvalid  <= 1'b0;
      r_araddr   <= '0;
      r_rready   <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_last     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_s_tready <= 1'b0;
            r_last     <= bus.s_axis_tlast;
            if (w_inb) begin
              r_arvalid <= 1'b1;
              r_araddr  <= w_addr[ADDR_WIDTH-1:0];
              r_state   <= S_AR;
            end else begin
              // no memory access: go straight to output with fill
              r_m_tdata  <= FILL_VALUE;
              r_m_tlast  <= bus.s_axis_tlast;
              r_m_tvalid <= 1'b1;
              r_state    <= S_OUT;
            end
          end else begin
            r_s_tready <= start;
          end
        end
        S_AR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (bus.m_axi_rvalid) begin
            r_rready   <= 1'b0;
            r_m_tdata  <= (bus.m_axi_rresp == 2'b00) ?
                          bus.m_axi_rdata : FILL_VALUE;
            r_m_tlast  <= r_last;
            r_m_tvalid <= 1'b1;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.m_axis_tready) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_s_tready <= start;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rectify_fetch.sv
// tb_rectify_fetch: directed + random coordinates against a raster-image model.
// Memory model returns word index (addr/4) as pixel data; delays and error responses configurable.
module tb_rectify_fetch;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int W  = 6;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  rectify_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  rectify_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .IMG_W(W), .IMG_H(H), .BASE_ADDR(0), .FILL_VALUE(32'd0)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rstn),
    .start        (start),
    .bus          (bus)
  );

  int checks = 0;
  int failures = 0;

  int ar_dly = 0;
  int r_dly = 0;
  bit err_next = 1'b0;
  int ar_cnt = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI read slave: word i holds value i
  initial begin : mem
    logic [AW-1:0] a;
    bit ok;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rid     = '0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && bus.m_axi_arvalid === 1'b1) begin
        a = bus.m_axi_araddr;
        check("araddr", a, exp_addr);
        check("ar_const",
              {bus.m_axi_arid, bus.m_axi_arlen, bus.m_axi_arsize,
               bus.m_axi_arburst, bus.m_axi_arlock, bus.m_axi_arcache,
               bus.m_axi_arprot},
              {8'h00, 8'h00, 3'd2, 2'd1, 1'b0, 4'b0011, 3'b000});
        for (int k = 0; k < ar_dly; k++) begin
          @(negedge clk);
          check("arvalid_hold", bus.m_axi_arvalid, 1);
          check("araddr_hold", bus.m_axi_araddr, a);
        end
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        bus.m_axi_arready = 1'b0;
        ar_cnt++;
        check("rready_on", bus.m_axi_rready, 1);
        ok = 1'b1;
        for (int k = 0; k < r_dly; k++) begin
          @(negedge clk);
          if (bus.m_axi_rready !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          bus.m_axi_rdata  = 32'(a >> 2);
          bus.m_axi_rresp  = err_next ? 2'b10 : 2'b00;
          bus.m_axi_rid    = IW'($urandom);
          bus.m_axi_rlast  = 1'b1;
          bus.m_axi_rvalid = 1'b1;
          @(negedge clk);
          bus.m_axi_rvalid = 1'b0;
          bus.m_axi_rlast  = 1'b0;
          bus.m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  task automatic send(int x, int y, bit last);
    int k;
    @(negedge clk);
    bus.s_axis_tdata  = {16'(y), 16'(x)};
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (bus.s_axis_tready === 1'b1) break;
      @(negedge clk);
    end
    check("accept_wait", k < 100, 1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic recv(logic [31:0] exp_d, bit exp_l, int hold);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid === 1'b1) break;
    end
    check("out_wait", k < 100, 1);
    check("tdata", bus.m_axis_tdata, exp_d);
    check("tlast", bus.m_axis_tlast, exp_l);
    if (hold > 0) begin
      bus.m_axis_tready = 1'b0;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        check("bp_tvalid", bus.m_axis_tvalid, 1);
        check("bp_tdata", bus.m_axis_tdata, exp_d);
        check("bp_stready", bus.s_axis_tready, 0);
        check("bp_arvalid", bus.m_axi_arvalid, 0);
      end
      bus.m_axis_tready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("tvalid_drop", bus.m_axis_tvalid, 0);
  endtask

  task automatic item(int x, int y, bit last, int hold);
    bit inb;
    int c0;
    logic [31:0] e;
    inb = (x >= 0) && (x < W) && (y >= 0) && (y < H);
    e = (inb && !err_next) ? 32'(y * W + x) : 32'd0;
    exp_addr = AW'((y * W + x) * 4);
    c0 = ar_cnt;
    send(x, y, last);
    recv(e, last, hold);
    check("ar_count", 64'(ar_cnt - c0), inb ? 64'd1 : 64'd0);
  endtask

  initial begin : main
    int k;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    start = 1'b1;
    rstn  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_rready", bus.m_axi_rready, 0);
    check("rst_stready", bus.s_axis_tready, 0);
    check("rst_mtvalid", bus.m_axis_tvalid, 0);
    check("rst_mtlast", bus.m_axis_tlast, 0);
    check("rst_mtdata", bus.m_axis_tdata, 0);
    check("rst_araddr", bus.m_axi_araddr, 0);
    rstn = 1'b1;

    item(2, 1, 1'b0, 0);

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        item(x, y, (x == W - 1) && (y == H - 1), 0);

    item(6, 0, 1'b0, 0);
    item(-1, 2, 1'b1, 0);
    item(0, 4, 1'b0, 0);

    item(3, 0, 1'b0, 10);

    ar_dly = 3;
    r_dly = 4;
    err_next = 1'b1;
    item(4, 2, 1'b1, 0);
    err_next = 1'b0;
    item(1, 3, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ar_dly   = $urandom_range(0, 3);
      r_dly    = $urandom_range(0, 3);
      err_next = ($urandom_range(0, 7) == 0);
      item($urandom_range(0, 9) - 2, $urandom_range(0, 7) - 2,
           1'($urandom), $urandom_range(0, 2));
    end
    err_next = 1'b0;

    // abandon a read in flight, then keep start low
    ar_dly = 0;
    r_dly = 20;
    exp_addr = AW'((1 * W + 1) * 4);
    send(1, 1, 1'b1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.m_axi_rready === 1'b1) break;
    end
    check("reach_r", k < 50, 1);
    start = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("rr_arvalid", bus.m_axi_arvalid, 0);
    check("rr_rready", bus.m_axi_rready, 0);
    check("rr_mtvalid", bus.m_axis_tvalid, 0);
    check("rr_mtdata", bus.m_axis_tdata, 0);
    check("rr_araddr", bus.m_axi_araddr, 0);
    bus.s_axis_tdata  = 32'h0000_0000;
    bus.s_axis_tvalid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("idle_stready", bus.s_axis_tready, 0);
      check("idle_mtvalid", bus.m_axis_tvalid, 0);
      check("idle_arvalid", bus.m_axi_arvalid, 0);
    end
    bus.s_axis_tvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rectify_fetch.md
Name: rectify_fetch

Overview:
- Pixel fetch stage of the image-rectification pipeline.
- Consumes a stream of source-pixel coordinates from the coordinate warper.
- For each coordinate, reads one 32-bit pixel word from image memory over an AXI4 read-only master port, then emits the pixel on an AXI-Stream master port in coordinate order.
- Coordinates outside the image are not read from memory; they produce a fill value.

Parameters:
- DATA_WIDTH, 32: AXI read data width and stream data width.
- ADDR_WIDTH, 16: AXI byte address width.
- ID_WIDTH, 8: AXI ID width.
- IMG_W, 6: source image width in pixels.
- IMG_H, 4: source image height in pixels.
- BASE_ADDR, 0: byte address of pixel (0,0).
- FILL_VALUE, 0: data emitted for out-of-bounds coordinates or read errors.

Ports:
- m_axi_aclk in 1: clock.
- m_axi_aresetn in 1: reset, synchronous, active-low.
- start in 1: level enable. New coordinates are accepted only while high.
- s_axis_tdata in 32: coordinate. [15:0] = x (column), [31:16] = y (row). Both signed 16-bit.
- s_axis_tvalid in 1 / s_axis_tready out 1 / s_axis_tlast in 1: coordinate stream.
- m_axis_tdata out DATA_WIDTH / m_axis_tvalid out 1 / m_axis_tready in 1 / m_axis_tlast out 1: pixel stream.
- m_axi_arid out ID_WIDTH; m_axi_araddr out ADDR_WIDTH; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arlock out 1; m_axi_arcache out 4; m_axi_arprot out 3; m_axi_arvalid out 1; m_axi_arready in 1: AXI read address channel.
- m_axi_rid in ID_WIDTH; m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1: AXI read data channel.

Behaviour:
- Constant AR fields:
  - arid = 0, arlen = 0 (single beat), arsize = log2(DATA_WIDTH/8) (2 for 32-bit), arburst = 01 (INCR), arlock = 0, arcache = 0011, arprot = 000.
- Reset (m_axi_aresetn low at clock edge):
  - State goes to IDLE.
  - arvalid, rready, s_axis_tready, m_axis_tvalid, m_axis_tlast = 0; m_axis_tdata = 0; araddr = 0.
  - Reset mid-transaction abandons the transaction with no output.
- FSM, one coordinate in flight at a time; all outputs registered:
  - IDLE: s_axis_tready = start. On s_axis_tvalid && s_axis_tready: latch x, y, tlast.
    - In bounds (0 <= x < IMG_W and 0 <= y < IMG_H): go to AR.
    - Otherwise: load FILL_VALUE and go to OUT.
  - AR: arvalid = 1, araddr = BASE_ADDR + (y*IMG_W + x)*DATA_WIDTH/8. Compute in 32 bits, truncate to ADDR_WIDTH. Hold until arready; then go to R.
  - R: rready = 1. On rvalid: latch rdata if rresp == 00, else FILL_VALUE. Go to OUT. rid and rlast are ignored.
  - OUT: m_axis_tvalid = 1; m_axis_tlast = latched coordinate tlast. Hold data and last stable until m_axis_tready; then go to IDLE.
- Timing:
  - s_axis_tready is high for exactly the accept cycle; it drops the cycle after the handshake.
  - Best-case in-bounds latency, with arready and rvalid immediate: coordinate accept at edge N; arvalid high N+1..N+2; rready high N+2..N+3; m_axis_tvalid from N+3.
  - Out-of-bounds: m_axis_tvalid from N+1.
- start deasserted mid-operation: the in-flight coordinate completes and outputs normally; no new coordinate is accepted.
- Backpressure: m_axis_tready low holds OUT indefinitely. No further AR is issued and s_axis_tready stays 0.
- Negative or oversize coordinates (e.g. x = -1, x = IMG_W, y = IMG_H) are out of bounds: no AXI traffic, FILL_VALUE output.
- Output order equals input order; exactly one output beat per input coordinate.

Test Plan:
- Setup: IMG_W=6, IMG_H=4, BASE_ADDR=0, memory word i = i. Reset 5 cycles, start=1, m_axis_tready=1. Coordinate (x=2, y=1) -> araddr=0x0020, arlen=0, arsize=2, arburst=1; output tdata=8.
- Raster scan of all 24 coordinates, tlast on the last -> outputs 0..23 in order; tlast only on the 23 beat.
- Coordinates (x=6, y=0), (x=-1, y=2), (x=0, y=4) -> no arvalid ever asserted; outputs 0 (FILL_VALUE) with correct tlast.
- m_axis_tready held low 10 cycles after the first pixel -> tvalid stays 1, data stable, s_axis_tready and arvalid stay 0; resumes correctly when released.
- arready delayed 3 cycles, rvalid delayed 4 cycles, rresp=10 on one read -> arvalid and araddr held stable until handshake; that beat outputs FILL_VALUE.
- Reset asserted while in R state; start low after reset -> all outputs 0; no new coordinate accepted while start=0.
